// File: rtl/axi_burst_wr_master.sv
// -----------------------------------------------------------------------------
// axi_burst_wr_master
//
// AXI4 write master. Accepts one command (start address, beat count) and a
// write-data stream, splits the command into INCR bursts capped at MAX_BEATS
// that never cross a 4 KB page, keeps up to MAX_OUTS bursts in flight and
// reports completion and B-channel errors.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   cmd_valid/cmd_ready       command handshake (ready only in IDLE)
//   cmd_addr, cmd_beats       start byte address (beat aligned), total beats
//   wd_valid/wd_ready/wd_data write-data stream, passed through to W
//   aw*                       AXI AW channel (INCR, full-width, fixed ID)
//   w*                        AXI W channel (all strobes set)
//   b*                        AXI B channel (always ready)
//   busy                      command in progress
//   done                      one-cycle pulse at command completion
//   err                       sticky error, cleared by the next command accept
// -----------------------------------------------------------------------------
module axi_burst_wr_master #(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 128,
  parameter int ID_W      = 4,
  parameter int AXI_ID    = 1,
  parameter int MAX_BEATS = 16,
  parameter int MAX_OUTS  = 8,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [CNT_W-1:0]    cmd_beats,
  input  logic                wd_valid,
  output logic                wd_ready,
  input  logic [DATA_W-1:0]   wd_data,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [ID_W-1:0]     awid,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [ID_W-1:0]     bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int BYTES      = DATA_W / 8;
  localparam int SZ         = $clog2(BYTES);
  localparam int PAGE_BEATS = 4096 / BYTES;
  localparam int LW         = (CNT_W > 13) ? CNT_W : 13;
  localparam int OUT_W      = $clog2(MAX_OUTS + 1);
  localparam int PTR_W      = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;
  localparam logic [ID_W-1:0] ID_C = ID_W'(AXI_ID);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  rem_q, rem_d, rem_next;
  logic              awvalid_q, awvalid_d;
  logic [OUT_W-1:0]  outs_q, outs_d;
  logic [OUT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [8:0]        fifo_mem [MAX_OUTS];
  logic [8:0]        beat_q;
  logic              busy_q, done_q, err_q;

  logic [LW-1:0]     page_room, len_ext;
  logic              accept, aw_hs, w_active, w_hs, w_pop, b_dec, b_bad;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Burst sizing: min(remaining, MAX_BEATS, beats left in the 4 KB page).
  // Depends only on registered state, so awaddr/awlen stay put during a stall.
  // ---------------------------------------------------------------------------
  // NOTE: combinational blocks use blocking '=' so later lines see earlier
  // results; clocked blocks use '<=' so every register samples pre-edge values.
  always_comb begin
    page_room = LW'(PAGE_BEATS) - LW'(addr_q[11:SZ]);
    len_ext   = LW'(rem_q);
    if (len_ext > LW'(MAX_BEATS)) len_ext = LW'(MAX_BEATS);
    if (len_ext > page_room)      len_ext = page_room;
  end

  assign cmd_ready = (state_q == IDLE) & ~rst;
  assign accept    = cmd_valid & cmd_ready;
  assign aw_hs     = awvalid_q & awready;
  assign rem_d     = rem_q - CNT_W'(len_ext);
  assign rem_next  = aw_hs ? rem_d : rem_q;

  // W engine is active only while a burst length is queued, so W never
  // runs ahead of its AW.
  assign w_active  = (fifo_cnt_q != '0);
  assign w_hs      = wd_valid & wready & w_active;
  assign wlast     = w_active & (beat_q == fifo_mem[rd_ptr_q] - 9'd1);
  assign w_pop     = w_hs & wlast;

  // A B with nothing outstanding is flagged but must not underflow outs.
  assign b_dec     = bvalid & (outs_q != '0);
  assign b_bad     = bvalid & ((bresp != 2'b00) | (bid != ID_C) | (outs_q == '0));

  always_comb begin
    outs_d = outs_q;
    if (aw_hs && !b_dec)      outs_d = outs_q + OUT_W'(1);
    else if (!aw_hs && b_dec) outs_d = outs_q - OUT_W'(1);
  end

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (aw_hs && !w_pop)      fifo_cnt_d = fifo_cnt_q + OUT_W'(1);
    else if (!aw_hs && w_pop) fifo_cnt_d = fifo_cnt_q - OUT_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q & ~awready;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = (cmd_beats != '0) ? ISSUE : DONE;
          awvalid_d = (cmd_beats != '0);
        end
      end
      ISSUE: begin
        if (aw_hs && rem_d == '0) state_d = DRAIN;
        // Only re-decide awvalid when it is low or just handshook; an asserted
        // awvalid is never withdrawn. Throttle on post-edge counts.
        if (!awvalid_q || awready)
          awvalid_d = (rem_next != '0) &&
                      (outs_d < OUT_W'(MAX_OUTS)) &&
                      (fifo_cnt_d < OUT_W'(MAX_OUTS));
      end
      DRAIN: begin
        if (fifo_cnt_q == '0 && outs_q == '0) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      awvalid_q  <= 1'b0;
      addr_q     <= '0;
      rem_q      <= '0;
      outs_q     <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      beat_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      awvalid_q  <= awvalid_d;
      outs_q     <= outs_d;
      fifo_cnt_q <= fifo_cnt_d;
      done_q     <= (state_q == DONE);

      if (accept) begin
        addr_q <= cmd_addr & ~ADDR_W'(BYTES - 1);
        rem_q  <= cmd_beats;
        busy_q <= 1'b1;
      end else if (aw_hs) begin
        addr_q <= addr_q + (ADDR_W'(len_ext) << SZ);
        rem_q  <= rem_d;
      end
      if (state_q == DONE) busy_q <= 1'b0;

      if (aw_hs) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (w_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (w_hs)  beat_q   <= w_pop ? '0 : beat_q + 9'd1;

      if (accept) err_q <= 1'b0;
      if (b_bad)  err_q <= 1'b1;
    end
  end

  // NOTE: the length storage has no reset; fifo_cnt_q gates every read, so
  // stale entries are never observed.
  always_ff @(posedge clk) begin
    if (aw_hs) fifo_mem[wr_ptr_q] <= 9'(len_ext);
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign awaddr   = addr_q;
  assign awlen    = 8'(len_ext - LW'(1));
  assign awsize   = 3'(SZ);
  assign awburst  = 2'b01;
  assign awid     = ID_C;
  assign awvalid  = awvalid_q;
  assign wdata    = wd_data;
  assign wstrb    = '1;
  assign wvalid   = wd_valid & w_active;
  assign wd_ready = wready & w_active;
  assign bready   = 1'b1;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
